inv_adder_sample_ctrl: RTL and testbench

Job sequencer for the 4-bit invertible p-bit ripple adder.
- Accepts one solve command at a time: mode, clamp operands, I_0 and sample count.
- Drives the adder's mode, clamp and reset inputs, then discards a burn-in window.
- Accumulates per-bit "ones" counts over the sample window and returns a majority-vote result through a valid/ready handshake.
- Replaces the hand-written sampling loops in benches and is the single owner of the adder instance.

---
 rtl/inv_adder_pkg.sv | 25 ++
 rtl/bit_vote_acc.sv | 34 +++
 rtl/inv_adder_sample_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_inv_adder_sample_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_adder_pkg.sv
// Shared types and constants for the invertible p-bit adder sample controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package inv_adder_pkg;

  localparam int STEP_W_DEF = 16;

  localparam logic [1:0] MODE_FWD = 2'd0;
  localparam logic [1:0] MODE_INV = 2'd1;
  localparam logic [1:0] MODE_SUB = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } ctrl_state_t;

  // Mode 3 has no meaning of its own in the adder; it runs as subtract.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_SUB : m;
  endfunction

endpackage

// File: rtl/bit_vote_acc.sv
// Single-bit ones counter with synchronous clear/enable and a majority compare.
// Latency: count updates one cycle after an enabled sample; vote is combinational on the count.
// Backpressure: none; the owner gates en.
// Ports: clk/reset_n, clr (zero the count), en (sample bit_in), steps (window length),
//        cnt (ones seen so far), vote (1 when 2*cnt > steps, ties give 0).
module bit_vote_acc
  import inv_adder_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic              bit_in,
  input  logic [STEP_W-1:0] steps,
  output logic [STEP_W-1:0] cnt,
  output logic              vote
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && bit_in) begin
      cnt <= cnt + STEP_W'(1);
    end
  end

  // Compare at STEP_W+1 bits so 2*cnt cannot wrap.
  assign vote = ({cnt, 1'b0} > {1'b0, steps});

endmodule

// File: rtl/inv_adder_sample_ctrl.sv
// Job sequencer for the 4-bit invertible p-bit adder: reset, burn-in, sample, majority vote.
// Latency: accept to res_valid = RST_CYC + BURN_IN + steps + 1 cycles.
// Backpressure: one job at a time (cmd_ready only in IDLE); result held until res_ready.
// Ports: cmd_* command in (valid/ready), abort cancels a running job, adder_* drive/observe
//        the adder, res_* majority-voted result (valid/ready), res_cnt_b raw b_out counts.
// Optional: define I0_ANNEAL_EN to ramp adder_i0 from 1 up to cmd_i0 during the job.
module inv_adder_sample_ctrl
  import inv_adder_pkg::*;
#(
  parameter int STEP_W  = STEP_W_DEF,
  parameter int BURN_IN = 16,
  parameter int RST_CYC = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_mode,
  input  logic [3:0]          cmd_a,
  input  logic [3:0]          cmd_b,
  input  logic [3:0]          cmd_sum,
  input  logic [3:0]          cmd_i0,
  input  logic                cmd_update_mode,
  input  logic [STEP_W-1:0]   cmd_steps,
  input  logic                abort,
  output logic                adder_reset,
  output logic [1:0]          adder_mode,
  output logic                adder_update_mode,
  output logic [3:0]          adder_a,
  output logic [3:0]          adder_b,
  output logic [3:0]          adder_sum,
  output logic [3:0]          adder_i0,
  input  logic [3:0]          adder_a_out,
  input  logic [3:0]          adder_b_out,
  input  logic [3:0]          adder_sum_out,
  input  logic                adder_overflow,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [3:0]          res_a,
  output logic [3:0]          res_b,
  output logic [3:0]          res_sum,
  output logic                res_ovf,
  output logic [4*STEP_W-1:0] res_cnt_b
);

  // One phase counter serves both the RST and SETTLE windows.
  localparam int PH_MAX = (RST_CYC > BURN_IN) ? RST_CYC : BURN_IN;
  localparam int PH_W   = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);
  localparam logic [PH_W-1:0] RST_LAST   = PH_W'(RST_CYC - 1);
  localparam logic [PH_W-1:0] BURN_LAST  = PH_W'((BURN_IN > 0) ? BURN_IN - 1 : 0);

  ctrl_state_t       state;
  logic [STEP_W-1:0] steps_q;
  logic [STEP_W-1:0] step_cnt;
  logic [PH_W-1:0]   cyc_cnt;

  logic        accept;
  logic        running;
  logic        acc_clr;
  logic        acc_en;
  logic [12:0] acc_bit;
  logic [12:0] vote;
  logic [STEP_W-1:0] cnt [13];

  assign accept  = (state == ST_IDLE) && cmd_valid && cmd_ready;
  assign running = (state == ST_RST) || (state == ST_SETTLE) || (state == ST_SAMPLE);
  // Clearing at acceptance means counts from an aborted or old job never leak forward.
  assign acc_clr = accept || (running && abort);
  // Abort beats the sample taken on the same cycle, including the final one.
  assign acc_en  = (state == ST_SAMPLE) && !abort;
  assign acc_bit = {adder_overflow, adder_sum_out, adder_b_out, adder_a_out};

  for (genvar g = 0; g < 13; g++) begin : g_acc
    bit_vote_acc #(.STEP_W(STEP_W)) u_acc (
      .clk    (clk),
      .reset_n(reset_n),
      .clr    (acc_clr),
      .en     (acc_en),
      .bit_in (acc_bit[g]),
      .steps  (steps_q),
      .cnt    (cnt[g]),
      .vote   (vote[g])
    );
  end

  // Results are only presented while res_valid is up; counts are frozen in DONE.
  assign res_a     = res_valid ? vote[3:0]  : 4'd0;
  assign res_b     = res_valid ? vote[7:4]  : 4'd0;
  assign res_sum   = res_valid ? vote[11:8] : 4'd0;
  assign res_ovf   = res_valid & vote[12];
  assign res_cnt_b = {cnt[7], cnt[6], cnt[5], cnt[4]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      cmd_ready         <= 1'b0;
      busy              <= 1'b0;
      res_valid         <= 1'b0;
      adder_reset       <= 1'b1;
      adder_mode        <= 2'd0;
      adder_update_mode <= 1'b0;
      adder_a           <= 4'd0;
      adder_b           <= 4'd0;
      adder_sum         <= 4'd0;
      steps_q           <= '0;
      step_cnt          <= '0;
      cyc_cnt           <= '0;
    end else if (running && abort) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      cmd_ready   <= 1'b1;
      adder_reset <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready   <= 1'b1;
          adder_reset <= 1'b1;
          if (accept) begin
            state             <= ST_RST;
            cmd_ready         <= 1'b0;
            busy              <= 1'b1;
            adder_mode        <= norm_mode(cmd_mode);
            adder_update_mode <= cmd_update_mode;
            adder_a           <= cmd_a;
            adder_b           <= cmd_b;
            adder_sum         <= cmd_sum;
            steps_q           <= cmd_steps;
            step_cnt          <= '0;
            cyc_cnt           <= '0;
          end
        end
        ST_RST: begin
          if (cyc_cnt == RST_LAST) begin
            cyc_cnt <= '0;
            if (BURN_IN != 0) begin
              state       <= ST_SETTLE;
              adder_reset <= 1'b0;
            end else if (steps_q == '0) begin
              state     <= ST_DONE;
              busy      <= 1'b0;
              res_valid <= 1'b1;
            end else begin
              state       <= ST_SAMPLE;
              adder_reset <= 1'b0;
            end
          end else begin
            cyc_cnt <= cyc_cnt + PH_W'(1);
          end
        end
        ST_SETTLE: begin
          if (cyc_cnt == BURN_LAST) begin
            cyc_cnt <= '0;
            if (steps_q == '0) begin
              state       <= ST_DONE;
              busy        <= 1'b0;
              res_valid   <= 1'b1;
              adder_reset <= 1'b1;
            end else begin
              state <= ST_SAMPLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + PH_W'(1);
          end
        end
        ST_SAMPLE: begin
          step_cnt <= step_cnt + STEP_W'(1);
          if (step_cnt == steps_q - STEP_W'(1)) begin
            state       <= ST_DONE;
            busy        <= 1'b0;
            res_valid   <= 1'b1;
            adder_reset <= 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef I0_ANNEAL_EN
  // Ramp I_0 from 1 toward the commanded value once per 2^(STEP_W/4) cycles of SETTLE/SAMPLE.
  localparam int RAMP_W = (STEP_W / 4 < 1) ? 1 : STEP_W / 4;
  logic [RAMP_W-1:0] ramp_cnt;
  logic [3:0]        i0_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adder_i0 <= 4'd0;
      i0_q     <= 4'd0;
      ramp_cnt <= '0;
    end else if (accept) begin
      i0_q     <= cmd_i0;
      adder_i0 <= (cmd_i0 == 4'd0) ? 4'd0 : 4'd1;
      ramp_cnt <= '0;
    end else if (state == ST_SETTLE || state == ST_SAMPLE) begin
      ramp_cnt <= ramp_cnt + RAMP_W'(1);
      if (ramp_cnt == {RAMP_W{1'b1}} && adder_i0 < i0_q) begin
        adder_i0 <= adder_i0 + 4'd1;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adder_i0 <= 4'd0;
    end else if (accept) begin
      adder_i0 <= cmd_i0;
    end
  end
`endif

endmodule

// File: tb/tb_inv_adder_sample_ctrl.sv
// Directed bench for inv_adder_sample_ctrl with a behavioural adder stand-in.
// Latency: n/a.
// Backpressure: res_ready held low in one scenario to exercise result hold.
module tb_inv_adder_sample_ctrl;
  import inv_adder_pkg::*;

  localparam int SW = 16;
  localparam int BI = 16;
  localparam int RC = 2;

  logic          clk;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_mode;
  logic [3:0]    cmd_a, cmd_b, cmd_sum, cmd_i0;
  logic          cmd_update_mode;
  logic [SW-1:0] cmd_steps;
  logic          abort;
  logic          adder_reset;
  logic [1:0]    adder_mode;
  logic          adder_update_mode;
  logic [3:0]    adder_a, adder_b, adder_sum, adder_i0;
  logic [3:0]    adder_a_out, adder_b_out, adder_sum_out;
  logic          adder_overflow;
  logic          busy;
  logic          res_valid;
  logic          res_ready;
  logic [3:0]    res_a, res_b, res_sum;
  logic          res_ovf;
  logic [4*SW-1:0] res_cnt_b;

  int n_vec;
  int n_err;
  int rst_hi;
  int mode_bad;

  // Adder stand-in: 0 = constant outputs, 1 = ideal arithmetic, 2 = b_out[0] toggler.
  int         stub_sel;
  logic [3:0] stub_sum;
  logic [3:0] stub_b;
  logic       tog_init;
  logic       tog;

  inv_adder_sample_ctrl #(.STEP_W(SW), .BURN_IN(BI), .RST_CYC(RC)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_mode         (cmd_mode),
    .cmd_a            (cmd_a),
    .cmd_b            (cmd_b),
    .cmd_sum          (cmd_sum),
    .cmd_i0           (cmd_i0),
    .cmd_update_mode  (cmd_update_mode),
    .cmd_steps        (cmd_steps),
    .abort            (abort),
    .adder_reset      (adder_reset),
    .adder_mode       (adder_mode),
    .adder_update_mode(adder_update_mode),
    .adder_a          (adder_a),
    .adder_b          (adder_b),
    .adder_sum        (adder_sum),
    .adder_i0         (adder_i0),
    .adder_a_out      (adder_a_out),
    .adder_b_out      (adder_b_out),
    .adder_sum_out    (adder_sum_out),
    .adder_overflow   (adder_overflow),
    .busy             (busy),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_a            (res_a),
    .res_b            (res_b),
    .res_sum          (res_sum),
    .res_ovf          (res_ovf),
    .res_cnt_b        (res_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) tog <= adder_reset ? tog_init : ~tog;

  always_comb begin
    adder_a_out    = 4'd0;
    adder_b_out    = 4'd0;
    adder_sum_out  = 4'd0;
    adder_overflow = 1'b0;
    case (stub_sel)
      0: begin
        adder_sum_out = stub_sum;
        adder_b_out   = stub_b;
      end
      1: begin
        adder_a_out = adder_a;
        if (adder_mode == MODE_FWD) begin
          adder_b_out = adder_b;
          {adder_overflow, adder_sum_out} = {1'b0, adder_a} + {1'b0, adder_b};
        end else begin
          adder_sum_out = adder_sum;
          adder_b_out   = adder_sum - adder_a;
        end
      end
      2: adder_b_out = {3'b000, tog};
      default: ;
    endcase
  end

  // Offer a command on a negedge, let one posedge accept it, return in cycle 1 of the job.
  task automatic start_job(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] s, input logic [3:0] i0, input logic [SW-1:0] st);
    @(negedge clk);
    cmd_mode = m; cmd_a = a; cmd_b = b; cmd_sum = s; cmd_i0 = i0; cmd_steps = st;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Count cycles from acceptance until res_valid, tracking adder_reset-while-busy and mode.
  task automatic wait_result(input int start, input int limit, input logic [1:0] exp_mode,
                             output int cyc);
    cyc = start;
    rst_hi = 0;
    mode_bad = 0;
    forever begin
      if (busy === 1'b1 && adder_reset === 1'b1) rst_hi++;
      if (adder_mode !== exp_mode) mode_bad++;
      if (res_valid === 1'b1 || cyc >= limit) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic handshake;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
    n_vec++; if (adder_reset !== 1'b1) begin n_err++; $display("FAIL rst_adder_reset got %b exp 1", adder_reset); end
    n_vec++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_err++; $display("FAIL rst_busy_valid got %b%b exp 00", busy, res_valid); end
    n_vec++; if ({adder_mode, adder_a, adder_b, adder_sum, adder_i0} !== 18'd0) begin n_err++; $display("FAIL rst_adder_outs got %h exp 0", {adder_mode, adder_a, adder_b, adder_sum, adder_i0}); end
    n_vec++; if ({res_a, res_b, res_sum, res_ovf} !== 13'd0 || res_cnt_b !== '0) begin n_err++; $display("FAIL rst_results got %h/%h exp 0", {res_a, res_b, res_sum, res_ovf}, res_cnt_b); end
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_forward;
    int cyc;
    stub_sel = 0; stub_sum = 4'h8; stub_b = 4'h0;
    start_job(MODE_FWD, 4'd1, 4'd7, 4'd0, 4'd5, SW'(10));
    n_vec++; if (adder_a !== 4'd1 || adder_b !== 4'd7 || adder_i0 !== 4'd5) begin n_err++; $display("FAIL fwd_clamps got a=%h b=%h i0=%h exp 1 7 5", adder_a, adder_b, adder_i0); end
    n_vec++; if (busy !== 1'b1 || adder_reset !== 1'b1) begin n_err++; $display("FAIL fwd_rst_phase got busy=%b rst=%b exp 1 1", busy, adder_reset); end
    wait_result(1, 100, MODE_FWD, cyc);
    n_vec++; if (cyc !== 29) begin n_err++; $display("FAIL fwd_latency got %0d exp 29", cyc); end
    n_vec++; if (res_sum !== 4'h8 || res_a !== 4'h0 || res_b !== 4'h0) begin n_err++; $display("FAIL fwd_result got a=%h b=%h s=%h exp 0 0 8", res_a, res_b, res_sum); end
    n_vec++; if (res_cnt_b !== '0) begin n_err++; $display("FAIL fwd_cnt_b got %h exp 0", res_cnt_b); end
    n_vec++; if (busy !== 1'b0 || adder_reset !== 1'b1) begin n_err++; $display("FAIL fwd_done_state got busy=%b rst=%b exp 0 1", busy, adder_reset); end
    handshake();
    n_vec++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin n_err++; $display("FAIL fwd_after_hs got rdy=%b vld=%b exp 1 0", cmd_ready, res_valid); end
  endtask

  task automatic test_subtract;
    int cyc;
    stub_sel = 1;
    start_job(MODE_SUB, 4'd3, 4'd0, 4'd12, 4'd4, SW'(1000));
    wait_result(1, 2000, MODE_SUB, cyc);
    n_vec++; if (cyc !== 1019) begin n_err++; $display("FAIL sub_latency got %0d exp 1019", cyc); end
    n_vec++; if (res_b !== 4'd9 || res_a !== 4'd3 || res_sum !== 4'd12) begin n_err++; $display("FAIL sub_result got a=%h b=%h s=%h exp 3 9 c", res_a, res_b, res_sum); end
    n_vec++; if (res_cnt_b !== {16'd1000, 16'd0, 16'd0, 16'd1000}) begin n_err++; $display("FAIL sub_cnt_b got %h exp 03e80000000003e8", res_cnt_b); end
    n_vec++; if (rst_hi !== 2) begin n_err++; $display("FAIL sub_reset_cycles got %0d exp 2", rst_hi); end
    n_vec++; if (mode_bad !== 0) begin n_err++; $display("FAIL sub_mode_stable got %0d bad cycles exp 0", mode_bad); end
    handshake();
  endtask

  task automatic test_tie;
    int cyc;
    stub_sel = 2; tog_init = 1'b0;
    start_job(MODE_FWD, 4'd0, 4'd0, 4'd0, 4'd1, SW'(4));
    wait_result(1, 100, MODE_FWD, cyc);
    n_vec++; if (cyc !== 23) begin n_err++; $display("FAIL tie4_latency got %0d exp 23", cyc); end
    n_vec++; if (res_cnt_b[SW-1:0] !== SW'(2) || res_b !== 4'd0) begin n_err++; $display("FAIL tie4_vote got cnt=%0d b=%h exp 2 0", res_cnt_b[SW-1:0], res_b); end
    handshake();
    tog_init = 1'b1;
    start_job(MODE_FWD, 4'd0, 4'd0, 4'd0, 4'd1, SW'(5));
    wait_result(1, 100, MODE_FWD, cyc);
    n_vec++; if (cyc !== 24) begin n_err++; $display("FAIL odd5_latency got %0d exp 24", cyc); end
    n_vec++; if (res_cnt_b[SW-1:0] !== SW'(3) || res_b !== 4'd1) begin n_err++; $display("FAIL odd5_vote got cnt=%0d b=%h exp 3 1", res_cnt_b[SW-1:0], res_b); end
    handshake();
  endtask

  task automatic test_abort;
    int cyc;
    int seen;
    stub_sel = 0; stub_sum = 4'h8; stub_b = 4'hF;
    start_job(MODE_FWD, 4'd0, 4'd0, 4'd0, 4'd1, SW'(10));
    repeat (22) @(negedge clk);           // cycle 23: fifth SAMPLE cycle
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_vec++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_idle got rdy=%b vld=%b busy=%b exp 1 0 0", cmd_ready, res_valid, busy); end
    n_vec++; if (res_cnt_b !== '0 || adder_reset !== 1'b1) begin n_err++; $display("FAIL abort_clear got cnt=%h rst=%b exp 0 1", res_cnt_b, adder_reset); end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) seen++;
    end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_result got %0d valid cycles exp 0", seen); end
    // Abort on the last sample cycle must still cancel.
    start_job(MODE_FWD, 4'd0, 4'd0, 4'd0, 4'd1, SW'(3));
    repeat (20) @(negedge clk);           // cycle 21: third and final SAMPLE cycle
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_vec++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL abort_last got vld=%b rdy=%b exp 0 1", res_valid, cmd_ready); end
    start_job(MODE_FWD, 4'd0, 4'd0, 4'd0, 4'd1, SW'(3));
    wait_result(1, 100, MODE_FWD, cyc);
    n_vec++; if (cyc !== 22) begin n_err++; $display("FAIL abort_next_latency got %0d exp 22", cyc); end
    n_vec++; if (res_cnt_b !== {4{16'd3}} || res_b !== 4'hF) begin n_err++; $display("FAIL abort_next_counts got %h b=%h exp 0003000300030003 f", res_cnt_b, res_b); end
    handshake();
  endtask

  task automatic test_back_to_back;
    int cyc;
    int bad;
    stub_sel = 0; stub_sum = 4'h0; stub_b = 4'h5;
    start_job(MODE_FWD, 4'd0, 4'd0, 4'd0, 4'd1, SW'(2));
    wait_result(1, 100, MODE_FWD, cyc);
    n_vec++; if (cyc !== 21) begin n_err++; $display("FAIL b2b_latency got %0d exp 21", cyc); end
    cmd_mode = 2'd3; cmd_a = 4'd2; cmd_b = 4'd4; cmd_sum = 4'd6; cmd_i0 = 4'd3; cmd_steps = SW'(7);
    cmd_valid = 1'b1;
    abort = 1'b1;                         // abort in DONE has no effect
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      abort = 1'b0;
      if (res_valid !== 1'b1 || res_b !== 4'h5 || cmd_ready !== 1'b0 || busy !== 1'b0 ||
          res_cnt_b !== {16'd0, 16'd2, 16'd0, 16'd2} || adder_mode !== MODE_FWD) bad++;
    end
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL b2b_hold got %0d unstable cycles exp 0", bad); end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    n_vec++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle got rdy=%b vld=%b exp 1 0", cmd_ready, res_valid); end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n_vec++; if (busy !== 1'b1 || adder_mode !== MODE_SUB || adder_a !== 4'd2) begin n_err++; $display("FAIL b2b_accept got busy=%b mode=%0d a=%h exp 1 2 2", busy, adder_mode, adder_a); end
    wait_result(1, 100, MODE_SUB, cyc);
    n_vec++; if (cyc !== 26 || res_b !== 4'h5) begin n_err++; $display("FAIL b2b_second got lat=%0d b=%h exp 26 5", cyc, res_b); end
    handshake();
  endtask

  task automatic test_async_reset;
    int cyc;
    stub_sel = 0; stub_sum = 4'h8; stub_b = 4'hF;
    start_job(MODE_SUB, 4'd5, 4'd0, 4'd9, 4'd2, SW'(5));
    repeat (9) @(negedge clk);            // cycle 10: inside SETTLE
    n_vec++; if (adder_reset !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL arst_settle got rst=%b busy=%b exp 0 1", adder_reset, busy); end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (adder_reset !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin n_err++; $display("FAIL arst_immediate got rst=%b vld=%b busy=%b rdy=%b exp 1 0 0 0", adder_reset, res_valid, busy, cmd_ready); end
    n_vec++; if (adder_a !== 4'd0 || adder_mode !== 2'd0) begin n_err++; $display("FAIL arst_adder_outs got a=%h mode=%0d exp 0 0", adder_a, adder_mode); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL arst_idle got rdy=%b busy=%b exp 1 0", cmd_ready, busy); end
    start_job(MODE_FWD, 4'd1, 4'd1, 4'd0, 4'd1, SW'(0));
    wait_result(1, 100, MODE_FWD, cyc);
    n_vec++; if (cyc !== 19) begin n_err++; $display("FAIL zero_latency got %0d exp 19", cyc); end
    n_vec++; if ({res_a, res_b, res_sum, res_ovf} !== 13'd0 || res_cnt_b !== '0) begin n_err++; $display("FAIL zero_results got %h/%h exp 0", {res_a, res_b, res_sum, res_ovf}, res_cnt_b); end
    handshake();
  endtask

  initial begin
    n_vec = 0; n_err = 0; rst_hi = 0; mode_bad = 0;
    reset_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    cmd_mode = 2'd0; cmd_a = 4'd0; cmd_b = 4'd0; cmd_sum = 4'd0; cmd_i0 = 4'd0;
    cmd_update_mode = 1'b0; cmd_steps = '0;
    stub_sel = 0; stub_sum = 4'd0; stub_b = 4'd0; tog_init = 1'b0;
    test_reset();
    test_forward();
    test_subtract();
    test_tie();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
